// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: condition codes, flag bit indices, fetch FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cpu_defs;

    // Condition codes as they appear in instruction bits [11:8]
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_HI = 4'h4;
    localparam logic [3:0] COND_LS = 4'h5;
    localparam logic [3:0] COND_GT = 4'h6;
    localparam logic [3:0] COND_LE = 4'h7;
    localparam logic [3:0] COND_FS = 4'h8;
    localparam logic [3:0] COND_FC = 4'h9;
    localparam logic [3:0] COND_LO = 4'hA;
    localparam logic [3:0] COND_HS = 4'hB;
    localparam logic [3:0] COND_LT = 4'hC;
    localparam logic [3:0] COND_GE = 4'hD;
    localparam logic [3:0] COND_UC = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Bit positions inside the 5-bit ALU flag register {N,Z,F,L,C}
    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_WAIT  = 2'd1,
        FS_VALID = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_cond_eval.sv
// Branch/jump condition evaluator: maps a 4-bit condition code and ALU flags to true/false.
// Latency: purely combinational.
// Backpressure: none.
// Ports: cond (4b code), flags ({N,Z,F,L,C}) -> cond_true.
module cond_eval
    import cpu_defs::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       cond_true
);

    logic n, z, f, l, c;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign f = flags[FLAG_F];
    assign l = flags[FLAG_L];
    assign c = flags[FLAG_C];

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_EQ: cond_true = z;
            COND_NE: cond_true = !z;
            COND_CS: cond_true = c;
            COND_CC: cond_true = !c;
            COND_HI: cond_true = l;
            COND_LS: cond_true = !l;
            COND_GT: cond_true = n;
            COND_LE: cond_true = !n;
            COND_FS: cond_true = f;
            COND_FC: cond_true = !f;
            COND_LO: cond_true = !l && !z;
            COND_HS: cond_true = l || z;
            COND_LT: cond_true = !n && !z;
            COND_GE: cond_true = n || z;
            COND_UC: cond_true = 1'b1;
            default: cond_true = 1'b0;   // COND_NV: never
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// PC, instruction fetch sequencer and instruction register feeding the control FSM.
// Latency: fetch_req in cycle T -> instr_valid in cycle T+1+MEM_LAT.
// Backpressure: busy=1 while a fetch is in flight; fetch_req and pc_en are ignored then.
// Ports: clk/reset; FSM commands (fetch_req, pc_en, br_en, jmp_en, cond, disp, jmp_target);
//        flags from ALU; addr_sel/data_addr for load/store; memory port A (mem_addr, mem_rdata);
//        status out (pc, link_addr, instr, instr_valid, busy, taken).
module fetch_unit
    import cpu_defs::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          MEM_LAT  = 1          // legal 1..4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic        pc_en,
    input  logic        br_en,
    input  logic        jmp_en,
    input  logic [3:0]  cond,
    input  logic [7:0]  disp,
    input  logic [15:0] jmp_target,
    input  logic [4:0]  flags,
    input  logic        addr_sel,
    input  logic [15:0] data_addr,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] pc,
    output logic [15:0] link_addr,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic        busy,
    output logic        taken
);

    localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

    fetch_state_t state, state_nxt;
    logic [1:0]   cnt, cnt_nxt;
    logic         instr_ld;
    logic         accept;
    logic         cond_true;
    logic         pc_upd;
    logic [15:0]  pc_inc;
    logic [15:0]  pc_rel;

    cond_eval u_cond_eval (
        .cond      (cond),
        .flags     (flags),
        .cond_true (cond_true)
    );

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    assign accept = fetch_req && (state != FS_WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FS_IDLE;
            cnt   <= 2'd0;
            instr <= 16'h0000;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (instr_ld) begin
                instr <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        instr_ld  = 1'b0;
        case (state)
            FS_IDLE, FS_VALID: begin
                if (fetch_req) begin
                    state_nxt = FS_WAIT;
                    cnt_nxt   = LAT_INIT;
                end
            end
            FS_WAIT: begin
                if (cnt != 2'd0) begin
                    cnt_nxt = cnt - 2'd1;
                end else begin
                    instr_ld  = 1'b1;
                    state_nxt = FS_VALID;
                end
            end
            default: state_nxt = FS_IDLE;
        endcase
    end

    assign busy        = (state == FS_WAIT);
    assign instr_valid = (state == FS_VALID);

    // The memory samples the address on the accepting edge, so the fetch
    // address must be pc even if the FSM still has addr_sel at data.
    assign mem_addr = (busy || accept || addr_sel) ? pc : data_addr;

    // ------------------------------------------------------------------
    // Program counter
    // ------------------------------------------------------------------
    assign pc_inc    = pc + 16'd1;
    assign pc_rel    = pc + {{8{disp[7]}}, disp};
    assign link_addr = pc_inc;

    // PC commands arriving while a fetch is outstanding are dropped so the
    // instruction being fetched always matches the pc reported alongside it.
    assign pc_upd = pc_en && (state != FS_WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= RESET_PC;
            taken <= 1'b0;
        end else if (pc_upd) begin
            if (jmp_en) begin
                pc    <= cond_true ? jmp_target : pc_inc;
                taken <= cond_true;
            end else if (br_en) begin
                pc    <= cond_true ? pc_rel : pc_inc;
                taken <= cond_true;
            end else begin
                pc    <= pc_inc;
                taken <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        fetch_req, pc_en, br_en, jmp_en;
    logic [3:0]  cond;
    logic [7:0]  disp;
    logic [15:0] jmp_target;
    logic [4:0]  flags;
    logic        addr_sel;
    logic [15:0] data_addr;

    // MEM_LAT = 1 instance
    logic [15:0] mem_rdata1, mem_addr1, pc1, link1, instr1;
    logic        valid1, busy1, taken1;
    // MEM_LAT = 3 instance
    logic [15:0] mem_rdata3, mem_addr3, pc3, link3, instr3;
    logic        valid3, busy3, taken3;

    int nvec = 0;
    int nerr = 0;

    fetch_unit #(.RESET_PC(16'h0010), .MEM_LAT(1)) u1 (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_en(pc_en),
        .br_en(br_en), .jmp_en(jmp_en), .cond(cond), .disp(disp),
        .jmp_target(jmp_target), .flags(flags), .addr_sel(addr_sel),
        .data_addr(data_addr), .mem_rdata(mem_rdata1), .mem_addr(mem_addr1),
        .pc(pc1), .link_addr(link1), .instr(instr1), .instr_valid(valid1),
        .busy(busy1), .taken(taken1)
    );

    fetch_unit #(.RESET_PC(16'h0010), .MEM_LAT(3)) u3 (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_en(pc_en),
        .br_en(br_en), .jmp_en(jmp_en), .cond(cond), .disp(disp),
        .jmp_target(jmp_target), .flags(flags), .addr_sel(addr_sel),
        .data_addr(data_addr), .mem_rdata(mem_rdata3), .mem_addr(mem_addr3),
        .pc(pc3), .link_addr(link3), .instr(instr3), .instr_valid(valid3),
        .busy(busy3), .taken(taken3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // Synchronous read memories: address sampled on the edge, data MEM_LAT cycles later.
    logic [15:0] p3a = 16'h0, p3b = 16'h0;
    initial mem_rdata1 = 16'h0;
    initial mem_rdata3 = 16'h0;
    always @(posedge clk) begin
        mem_rdata1 <= memf(mem_addr1);
        p3a        <= memf(mem_addr3);
        p3b        <= p3a;
        mem_rdata3 <= p3b;
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        pc_en, br_en, jmp_en;
        logic [3:0]  cond;
        logic [7:0]  disp;
        logic [15:0] tgt;
        logic [4:0]  flags;
        logic [15:0] exp_link;
        logic [15:0] exp_pc;
        logic        exp_taken;
    } vec_t;

    vec_t vt[24];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //           pc_en br    jmp   cond   disp    target     flags     link       pc         taken
        vt[0]  = '{1'b1, 1'b0, 1'b1, 4'hE, 8'h00, 16'hFFFF, 5'b00000, 16'h0011, 16'hFFFF, 1'b1};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 4'hE, 8'h00, 16'h0020, 5'b00000, 16'h0001, 16'h0020, 1'b1};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 4'h0, 8'hF0, 16'h0000, 5'b01000, 16'h0021, 16'h0010, 1'b1};
        vt[4]  = '{1'b1, 1'b0, 1'b1, 4'hE, 8'h00, 16'h0020, 5'b00000, 16'h0011, 16'h0020, 1'b1};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 4'h0, 8'hF0, 16'h0000, 5'b00000, 16'h0021, 16'h0021, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 1'b1, 4'hF, 8'h00, 16'h5555, 5'b11111, 16'h0022, 16'h0022, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 1'b1, 4'hE, 8'h05, 16'h1234, 5'b00000, 16'h0023, 16'h1234, 1'b1};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 4'hE, 8'h00, 16'h0002, 5'b00000, 16'h1235, 16'h0002, 1'b1};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 4'hE, 8'hFC, 16'h0000, 5'b00000, 16'h0003, 16'hFFFE, 1'b1};
        vt[10] = '{1'b1, 1'b1, 1'b0, 4'h1, 8'h02, 16'h0000, 5'b00000, 16'hFFFF, 16'h0000, 1'b1};
        vt[11] = '{1'b1, 1'b1, 1'b0, 4'hA, 8'h01, 16'h0000, 5'b00000, 16'h0001, 16'h0001, 1'b1};
        vt[12] = '{1'b1, 1'b1, 1'b0, 4'hB, 8'h01, 16'h0000, 5'b00000, 16'h0002, 16'h0002, 1'b0};
        vt[13] = '{1'b1, 1'b1, 1'b0, 4'h6, 8'h10, 16'h0000, 5'b10000, 16'h0003, 16'h0012, 1'b1};
        vt[14] = '{1'b1, 1'b1, 1'b0, 4'hC, 8'h10, 16'h0000, 5'b10000, 16'h0013, 16'h0013, 1'b0};
        vt[15] = '{1'b1, 1'b1, 1'b0, 4'h2, 8'h7F, 16'h0000, 5'b00001, 16'h0014, 16'h0092, 1'b1};
        vt[16] = '{1'b1, 1'b1, 1'b0, 4'h9, 8'h7F, 16'h0000, 5'b00100, 16'h0093, 16'h0093, 1'b0};
        vt[17] = '{1'b1, 1'b0, 1'b1, 4'h5, 8'h00, 16'h7777, 5'b00010, 16'h0094, 16'h0094, 1'b0};
        vt[18] = '{1'b1, 1'b1, 1'b0, 4'hD, 8'h80, 16'h0000, 5'b01000, 16'h0095, 16'h0014, 1'b1};
        vt[19] = '{1'b1, 1'b0, 1'b0, 4'hE, 8'h05, 16'h9999, 5'b00000, 16'h0015, 16'h0015, 1'b0};
        vt[20] = '{1'b1, 1'b1, 1'b0, 4'h4, 8'h03, 16'h0000, 5'b00010, 16'h0016, 16'h0018, 1'b1};
        vt[21] = '{1'b1, 1'b1, 1'b0, 4'h7, 8'hFF, 16'h0000, 5'b00000, 16'h0019, 16'h0017, 1'b1};
        vt[22] = '{1'b1, 1'b1, 1'b0, 4'h8, 8'h02, 16'h0000, 5'b00100, 16'h0018, 16'h0019, 1'b1};
        vt[23] = '{1'b1, 1'b1, 1'b0, 4'h3, 8'h02, 16'h0000, 5'b00001, 16'h001A, 16'h001A, 1'b0};

        reset = 1'b1; fetch_req = 1'b0; pc_en = 1'b0; br_en = 1'b0; jmp_en = 1'b0;
        cond = 4'h0; disp = 8'h00; jmp_target = 16'h0000; flags = 5'b0;
        addr_sel = 1'b1; data_addr = 16'h0000;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst_pc", pc1, 16'h0010);
        chk("rst_instr", instr1, 16'h0000);
        chk("rst_valid", {15'b0, valid1}, 16'h0);
        chk("rst_busy", {15'b0, busy1}, 16'h0);
        chk("rst_taken", {15'b0, taken1}, 16'h0);
        chk("rst_link", link1, 16'h0011);
        reset = 1'b0;

        // ---------------- fetch, MEM_LAT=1 ----------------
        @(negedge clk);
        fetch_req = 1'b1; addr_sel = 1'b0; data_addr = 16'h00AB;
        #1 chk("accept_mem_addr", mem_addr1, 16'h0010);
        @(negedge clk);
        fetch_req = 1'b0;
        chk("lat1_busy_T1", {15'b0, busy1}, 16'h1);
        chk("lat1_valid_T1", {15'b0, valid1}, 16'h0);
        #1 chk("wait_mem_addr", mem_addr1, 16'h0010);
        @(negedge clk);
        chk("lat1_valid_T2", {15'b0, valid1}, 16'h1);
        chk("lat1_busy_T2", {15'b0, busy1}, 16'h0);
        chk("lat1_instr", instr1, memf(16'h0010));
        #1 chk("valid_data_addr", mem_addr1, 16'h00AB);
        addr_sel = 1'b1;
        #1 chk("valid_pc_addr", mem_addr1, 16'h0010);
        repeat (2) @(negedge clk);   // let the MEM_LAT=3 copy finish too

        // ---------------- MEM_LAT=3 latency, pc_en during WAIT ----------------
        fetch_req = 1'b1;
        @(negedge clk);                       // T+1
        fetch_req = 1'b0; pc_en = 1'b1;
        chk("lat3_busy_T1", {15'b0, busy3}, 16'h1);
        chk("lat3_valid_T1", {15'b0, valid3}, 16'h0);
        @(negedge clk);                       // T+2
        pc_en = 1'b0;
        chk("lat3_pc_hold", pc3, 16'h0010);
        chk("lat1_pc_hold", pc1, 16'h0010);
        chk("lat3_busy_T2", {15'b0, busy3}, 16'h1);
        @(negedge clk);                       // T+3
        chk("lat3_busy_T3", {15'b0, busy3}, 16'h1);
        chk("lat3_valid_T3", {15'b0, valid3}, 16'h0);
        @(negedge clk);                       // T+4
        chk("lat3_valid_T4", {15'b0, valid3}, 16'h1);
        chk("lat3_busy_T4", {15'b0, busy3}, 16'h0);
        chk("lat3_instr", instr3, memf(16'h0010));

        // ---------------- PC command table ----------------
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            pc_en = vt[i].pc_en; br_en = vt[i].br_en; jmp_en = vt[i].jmp_en;
            cond = vt[i].cond; disp = vt[i].disp; jmp_target = vt[i].tgt;
            flags = vt[i].flags;
            #1 chk($sformatf("v%0d_link", i), link1, vt[i].exp_link);
            @(negedge clk);
            pc_en = 1'b0; br_en = 1'b0; jmp_en = 1'b0;
            chk($sformatf("v%0d_pc", i), pc1, vt[i].exp_pc);
            chk($sformatf("v%0d_taken", i), {15'b0, taken1}, {15'b0, vt[i].exp_taken});
        end

        // ---------------- fetch_req with pc_en: fetch uses old pc ----------------
        @(negedge clk);
        fetch_req = 1'b1; pc_en = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0; pc_en = 1'b0;
        chk("same_cycle_pc", pc1, 16'h001B);
        @(negedge clk);
        chk("same_cycle_valid", {15'b0, valid1}, 16'h1);
        chk("same_cycle_instr", instr1, memf(16'h001A));
        repeat (3) @(negedge clk);
        chk("lat3_same_cycle_instr", instr3, memf(16'h001A));

        // ---------------- reset mid-fetch ----------------
        @(negedge clk);
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0; addr_sel = 1'b0; data_addr = 16'h00AB;
        chk("mid_busy", {15'b0, busy3}, 16'h1);
        #1 chk("mid_wait_addr", mem_addr3, 16'h001B);
        reset = 1'b1;
        #1;
        chk("mid_rst_instr", instr3, 16'h0000);
        chk("mid_rst_valid", {15'b0, valid3}, 16'h0);
        chk("mid_rst_busy", {15'b0, busy3}, 16'h0);
        chk("mid_rst_pc", pc3, 16'h0010);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("late_valid", {15'b0, valid3}, 16'h0);
        chk("late_instr", instr3, 16'h0000);
        chk("late_busy", {15'b0, busy3}, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
